// File: rtl/fp_seq_pkg.sv
// fp_seq_pkg
// Shared definitions for the FP coprocessor issue/retire sequencer:
//   - FSM state encoding
//   - coprocessor op-select constants
//   - coprocessor status bit positions
//   - sizing helper for the latency counter
package fp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXEC   = 2'd1,
    RESULT = 2'd2
  } fp_seq_state_e;

  localparam logic FP_OP_ADD = 1'b0;
  localparam logic FP_OP_MUL = 1'b1;

  localparam int FP_ST_ZERO    = 0;
  localparam int FP_ST_INF     = 1;
  localparam int FP_ST_INVALID = 2;
  localparam int FP_ST_TINY    = 3;
  localparam int FP_ST_HUGE    = 4;
  localparam int FP_ST_INEXACT = 5;

  // Bits needed to hold a countdown from latency down to zero.
  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/fp_coproc_sequencer.sv
// fp_coproc_sequencer
// Issue/retire controller for the half-precision FP coprocessor that sits
// beside this block. Accepts one op at a time, drives the coprocessor inputs
// from registers, waits out the coprocessor latency, captures result/status
// with the destination tag and offers them to writeback. Keeps sticky
// exception flags over all retired (captured) ops.
//
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   issue_*               valid/ready issue channel from ID/EX (op, rnd, a, b, tag)
//   flush_i               abort whatever is in flight, highest priority
//   cp_input1_o/2_o, cp_op_o, cp_rnd_o   registered coprocessor inputs
//   cp_result_i, cp_status_i             coprocessor registered outputs
//   wb_*                  valid/ready writeback channel (data, tag, status)
//   clr_flags_i           clear sticky flags
//   sticky_flags_o        OR of captured status since last clear
//   busy_o                high whenever the FSM is not IDLE
module fp_coproc_sequencer
  import fp_seq_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int STATUS_BIT = 8,
  parameter int TAG_WIDTH  = 3,
  parameter int FP_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic                  issue_op_i,
  input  logic [2:0]            issue_rnd_i,
  input  logic [DATA_WIDTH-1:0] issue_a_i,
  input  logic [DATA_WIDTH-1:0] issue_b_i,
  input  logic [TAG_WIDTH-1:0]  issue_tag_i,
  input  logic                  flush_i,
  output logic [DATA_WIDTH-1:0] cp_input1_o,
  output logic [DATA_WIDTH-1:0] cp_input2_o,
  output logic                  cp_op_o,
  output logic [2:0]            cp_rnd_o,
  input  logic [DATA_WIDTH-1:0] cp_result_i,
  input  logic [STATUS_BIT-1:0] cp_status_i,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic [TAG_WIDTH-1:0]  wb_tag_o,
  output logic [STATUS_BIT-1:0] wb_status_o,
  input  logic                  clr_flags_i,
  output logic [STATUS_BIT-1:0] sticky_flags_o
  ,
  output logic                  busy_o
);

  localparam int               CNT_W    = cnt_width(FP_LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FP_LATENCY);

  fp_seq_state_e          state;
  logic [CNT_W-1:0]       cnt;
  logic [TAG_WIDTH-1:0]   tag_held;
  logic                   accept;
  logic                   capture;

  // Issue readiness: IDLE always, RESULT only when writeback drains this cycle.
  // Held low during reset and while a flush is pending.
  always_comb begin
    issue_ready_o = 1'b0;
    if (!rst || flush_i) begin
      issue_ready_o = 1'b0;
    end else begin
      case (state)
        IDLE:    issue_ready_o = 1'b1;
        RESULT:  issue_ready_o = wb_ready_i;
        default: issue_ready_o = 1'b0;
      endcase
    end
  end

  assign accept  = issue_valid_i & issue_ready_o;
  // Coprocessor output is valid in the last EXEC cycle; a flush discards it.
  assign capture = (state == EXEC) && (cnt == '0) && !flush_i;
  assign busy_o  = (state != IDLE);

  // Main FSM: operand launch, latency countdown, result capture and retire.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      tag_held    <= '0;
      cp_input1_o <= '0;
      cp_input2_o <= '0;
      cp_op_o     <= 1'b0;
      cp_rnd_o    <= 3'd0;
      wb_valid_o  <= 1'b0;
      wb_data_o   <= '0;
      wb_tag_o    <= '0;
      wb_status_o <= '0;
    end else if (flush_i) begin
      state      <= IDLE;
      cnt        <= '0;
      wb_valid_o <= 1'b0;
    end else if (accept) begin
      // Covers both a fresh issue from IDLE and back-to-back on the retire
      // edge; any result being presented is consumed at this same edge.
      state       <= EXEC;
      cnt         <= CNT_LOAD;
      tag_held    <= issue_tag_i;
      cp_input1_o <= issue_a_i;
      cp_input2_o <= issue_b_i;
      cp_op_o     <= issue_op_i;
      cp_rnd_o    <= issue_rnd_i;
      wb_valid_o  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state <= IDLE;
        end
        EXEC: begin
          if (cnt == '0) begin
            wb_data_o   <= cp_result_i;
            wb_status_o <= cp_status_i;
            wb_tag_o    <= tag_held;
            wb_valid_o  <= 1'b1;
            state       <= RESULT;
          end else begin
            cnt <= cnt - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        RESULT: begin
          if (wb_ready_i) begin
            wb_valid_o <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          state      <= IDLE;
          wb_valid_o <= 1'b0;
        end
      endcase
    end
  end

  // Sticky exception flags: a clear coinciding with a capture leaves exactly
  // the captured status (clear first, then set).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sticky_flags_o <= '0;
    end else if (clr_flags_i) begin
      sticky_flags_o <= capture ? cp_status_i : '0;
    end else if (capture) begin
      sticky_flags_o <= sticky_flags_o | cp_status_i;
    end
  end

endmodule

// File: tb/tb_fp_coproc_sequencer.sv
module tb_fp_coproc_sequencer;
  import fp_seq_pkg::*;

  localparam int DW  = 16;
  localparam int SW  = 8;
  localparam int TW  = 3;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0;
  logic          issue_ready;
  logic          issue_op = 1'b0;
  logic [2:0]    issue_rnd = 3'd0;
  logic [DW-1:0] issue_a = 16'h0000;
  logic [DW-1:0] issue_b = 16'h0000;
  logic [TW-1:0] issue_tag = 3'd0;
  logic          flush = 1'b0;
  logic [DW-1:0] cp_in1, cp_in2;
  logic          cp_op;
  logic [2:0]    cp_rnd;
  logic [DW-1:0] cp_result;
  logic [SW-1:0] cp_status;
  logic          wb_valid;
  logic          wb_ready = 1'b1;
  logic [DW-1:0] wb_data;
  logic [TW-1:0] wb_tag;
  logic [SW-1:0] wb_status;
  logic          clr_flags = 1'b0;
  logic [SW-1:0] sticky;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int retire_cnt = 0;
  int rc;

  always #5 clk = ~clk;

  fp_coproc_sequencer #(.DATA_WIDTH(DW), .STATUS_BIT(SW), .TAG_WIDTH(TW), .FP_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_op_i(issue_op),
    .issue_rnd_i(issue_rnd), .issue_a_i(issue_a), .issue_b_i(issue_b), .issue_tag_i(issue_tag),
    .flush_i(flush),
    .cp_input1_o(cp_in1), .cp_input2_o(cp_in2), .cp_op_o(cp_op), .cp_rnd_o(cp_rnd),
    .cp_result_i(cp_result), .cp_status_i(cp_status),
    .wb_valid_o(wb_valid), .wb_ready_i(wb_ready), .wb_data_o(wb_data), .wb_tag_o(wb_tag),
    .wb_status_o(wb_status), .clr_flags_i(clr_flags), .sticky_flags_o(sticky), .busy_o(busy)
  );

  // Coprocessor stand-in: fp16 results for the operand pairs used here.
  function automatic logic [23:0] fp_model(input logic op, input logic [15:0] a, input logic [15:0] b);
    case ({op, a, b})
      {FP_OP_ADD, 16'h3C00, 16'h4000}: return {16'h4200, 8'h00};
      {FP_OP_ADD, 16'h3C00, 16'h3C00}: return {16'h4000, 8'h00};
      {FP_OP_ADD, 16'h3C00, 16'h1000}: return {16'h3C00, 8'h20};
      {FP_OP_MUL, 16'h4000, 16'h4000}: return {16'h4400, 8'h00};
      {FP_OP_MUL, 16'h7BFF, 16'h7BFF}: return {16'h7C00, 8'h32};
      default:                         return {a ^ b, 8'h04};
    endcase
  endfunction

  logic [23:0] cp_now;
  logic [DW-1:0] pipe_res [LAT];
  logic [SW-1:0] pipe_st [LAT];
  always_comb cp_now = fp_model(cp_op, cp_in1, cp_in2);
  always @(posedge clk) begin
    pipe_res[0] <= cp_now[23:8];
    pipe_st[0]  <= cp_now[7:0];
    for (int i = 1; i < LAT; i++) begin
      pipe_res[i] <= pipe_res[i-1];
      pipe_st[i]  <= pipe_st[i-1];
    end
  end
  assign cp_result = pipe_res[LAT-1];
  assign cp_status = pipe_st[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic [TW-1:0] tag;
    logic [SW-1:0] status;
  } sb_t;
  sb_t sb_q[$];
  sb_t cur_exp;

  typedef struct {
    logic          op;
    logic [2:0]    rnd;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [TW-1:0] tag;
    logic          clr;
    logic [DW-1:0] exp_data;
    logic [SW-1:0] exp_status;
    logic [SW-1:0] exp_sticky;
  } vec_t;
  vec_t vecs[5];
  vec_t v_ovf, v_fresh;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: push expected on accept, pop and compare on retire.
  always @(negedge clk) begin
    if (!rst || flush) begin
      sb_q.delete();
    end else begin
      if (wb_valid && wb_ready) begin
        retire_cnt++;
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: retire tag %h data %h with empty queue", wb_tag, wb_data);
        end else begin
          sb_t e;
          e = sb_q.pop_front();
          chk("sb_data", wb_data, e.data);
          chk("sb_tag", wb_tag, e.tag);
          chk("sb_status", wb_status, e.status);
        end
      end
      if (issue_valid && issue_ready) sb_q.push_back(cur_exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic op, input logic [2:0] rnd, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] tag, input logic [15:0] ed, input logic [7:0] es);
    issue_op  = op;
    issue_rnd = rnd;
    issue_a   = a;
    issue_b   = b;
    issue_tag = tag;
    cur_exp   = '{data: ed, tag: tag, status: es};
    issue_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) begin
      #1;
      acc = issue_ready;
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL %s: issue not accepted within 20 cycles", name);
    end
  endtask

  task automatic wait_wb(input string name);
    int n;
    n = 0;
    while (!wb_valid && n < 20) begin
      step();
      n++;
    end
    if (!wb_valid) begin
      checks++;
      errors++;
      $display("FAIL %s: wb_valid not seen within 20 cycles", name);
    end
  endtask

  task automatic run_vec(input vec_t v);
    wb_ready = 1'b1;
    drive_op(v.op, v.rnd, v.a, v.b, v.tag, v.exp_data, v.exp_status);
    wait_accept("vec_accept");
    chk("vec_cp_in1", cp_in1, v.a);
    chk("vec_cp_in2", cp_in2, v.b);
    chk("vec_cp_op", cp_op, v.op);
    chk("vec_cp_rnd", cp_rnd, v.rnd);
    for (int k = 0; k <= LAT; k++) begin
      chk("vec_exec_wb_low", wb_valid, 1'b0);
      chk("vec_exec_busy", busy, 1'b1);
      chk("vec_exec_ready", issue_ready, 1'b0);
      if (k == LAT) clr_flags = v.clr;
      step();
    end
    clr_flags = 1'b0;
    chk("vec_wb_high", wb_valid, 1'b1);
    chk("vec_wb_data", wb_data, v.exp_data);
    chk("vec_wb_tag", wb_tag, v.tag);
    chk("vec_sticky", sticky, v.exp_sticky);
    step();
    chk("vec_retired", wb_valid, 1'b0);
    chk("vec_idle", busy, 1'b0);
    chk("vec_cp_hold", cp_in1, v.a);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{FP_OP_ADD, 3'd0, 16'h3C00, 16'h4000, 3'd5, 1'b0, 16'h4200, 8'h00, 8'h00};
    vecs[1] = '{FP_OP_MUL, 3'd0, 16'h7BFF, 16'h7BFF, 3'd1, 1'b0, 16'h7C00, 8'h32, 8'h32};
    vecs[2] = '{FP_OP_ADD, 3'd0, 16'h3C00, 16'h3C00, 3'd2, 1'b0, 16'h4000, 8'h00, 8'h32};
    vecs[3] = '{FP_OP_ADD, 3'd0, 16'h3C00, 16'h1000, 3'd3, 1'b1, 16'h3C00, 8'h20, 8'h20};
    vecs[4] = '{FP_OP_MUL, 3'd1, 16'h4000, 16'h4000, 3'd7, 1'b0, 16'h4400, 8'h00, 8'h20};
    v_ovf   = '{FP_OP_MUL, 3'd0, 16'h7BFF, 16'h7BFF, 3'd4, 1'b0, 16'h7C00, 8'h32, 8'h32};
    v_fresh = '{FP_OP_ADD, 3'd0, 16'h3C00, 16'h3C00, 3'd6, 1'b0, 16'h4000, 8'h00, 8'h00};

    // Reset state
    #2 rst = 1'b0;
    #2;
    chk("rst_ready", issue_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wb_valid", wb_valid, 1'b0);
    chk("rst_sticky", sticky, 8'h00);
    chk("rst_cp_in1", cp_in1, 16'h0000);
    step();
    step();
    rst = 1'b1;
    #1;
    chk("rst_release_ready", issue_ready, 1'b1);
    step();

    // Table-driven single ops (latency, data, sticky accumulate/clear)
    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back with wb_ready tied high
    rc = retire_cnt;
    wb_ready = 1'b1;
    drive_op(FP_OP_MUL, 3'd0, 16'h4000, 16'h4000, 3'd4, 16'h4400, 8'h00);
    wait_accept("b2b_first");
    drive_op(FP_OP_ADD, 3'd0, 16'h3C00, 16'h3C00, 3'd6, 16'h4000, 8'h00);
    for (int k = 0; k <= LAT; k++) begin
      #1;
      chk("b2b_exec_ready", issue_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    chk("b2b_result_valid", wb_valid, 1'b1);
    chk("b2b_result_ready", issue_ready, 1'b1);
    step();
    issue_valid = 1'b0;
    chk("b2b_reissue_busy", busy, 1'b1);
    chk("b2b_reissue_wb_low", wb_valid, 1'b0);
    chk("b2b_reissue_cp_in1", cp_in1, 16'h3C00);
    for (int k = 0; k <= LAT; k++) step();
    chk("b2b_second_valid", wb_valid, 1'b1);
    step();
    chk("b2b_done", wb_valid, 1'b0);
    chk("b2b_retires", retire_cnt, rc + 2);
    chk("b2b_sticky", sticky, 8'h20);

    // Writeback stall
    wb_ready = 1'b0;
    drive_op(FP_OP_ADD, 3'd0, 16'h3C00, 16'h4000, 3'd5, 16'h4200, 8'h00);
    wait_accept("stall_accept");
    wait_wb("stall_wait");
    rc = retire_cnt;
    drive_op(FP_OP_MUL, 3'd0, 16'h4000, 16'h4000, 3'd2, 16'h4400, 8'h00);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stall_valid", wb_valid, 1'b1);
      chk("stall_data", wb_data, 16'h4200);
      chk("stall_tag", wb_tag, 3'd5);
      chk("stall_busy", busy, 1'b1);
      chk("stall_ready", issue_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    issue_valid = 1'b0;
    wb_ready = 1'b1;
    step();
    chk("stall_released", wb_valid, 1'b0);
    chk("stall_one_retire", retire_cnt, rc + 1);
    step();
    chk("stall_no_second_retire", retire_cnt, rc + 1);

    // Flush in the first EXEC cycle
    rc = retire_cnt;
    drive_op(FP_OP_MUL, 3'd0, 16'h7BFF, 16'h7BFF, 3'd1, 16'h7C00, 8'h32);
    wait_accept("flush_exec_accept");
    flush = 1'b1;
    drive_op(FP_OP_ADD, 3'd0, 16'h3C00, 16'h3C00, 3'd2, 16'h4000, 8'h00);
    #1;
    chk("flush_ready_low", issue_ready, 1'b0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue_valid = 1'b0;
    chk("flush_exec_idle", busy, 1'b0);
    for (int k = 0; k < 3; k++) begin
      chk("flush_exec_no_wb", wb_valid, 1'b0);
      step();
    end
    chk("flush_exec_sticky", sticky, 8'h20);
    chk("flush_exec_no_retire", retire_cnt, rc);

    // Flush while a result is presented
    wb_ready = 1'b0;
    drive_op(FP_OP_ADD, 3'd0, 16'h3C00, 16'h3C00, 3'd2, 16'h4000, 8'h00);
    wait_accept("flush_res_accept");
    wait_wb("flush_res_wait");
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_res_wb_low", wb_valid, 1'b0);
    chk("flush_res_idle", busy, 1'b0);
    wb_ready = 1'b1;
    step();
    chk("flush_res_no_retire", retire_cnt, rc);
    chk("flush_res_sticky", sticky, 8'h20);

    // Clear alone, then overflow sets sticky again
    clr_flags = 1'b1;
    step();
    clr_flags = 1'b0;
    chk("clr_alone", sticky, 8'h00);
    run_vec(v_ovf);

    // Asynchronous reset mid-EXEC
    drive_op(FP_OP_ADD, 3'd0, 16'h3C00, 16'h4000, 3'd5, 16'h4200, 8'h00);
    wait_accept("rst_mid_accept");
    rst = 1'b0;
    #1;
    chk("rstm_wb_valid", wb_valid, 1'b0);
    chk("rstm_busy", busy, 1'b0);
    chk("rstm_ready", issue_ready, 1'b0);
    chk("rstm_cp_in1", cp_in1, 16'h0000);
    chk("rstm_cp_in2", cp_in2, 16'h0000);
    chk("rstm_wb_data", wb_data, 16'h0000);
    chk("rstm_wb_status", wb_status, 8'h00);
    chk("rstm_wb_tag", wb_tag, 3'd0);
    chk("rstm_sticky", sticky, 8'h00);
    step();
    step();
    rst = 1'b1;
    step();
    chk("rstm_release_ready", issue_ready, 1'b1);
    run_vec(v_fresh);

    step();
    chk("sb_empty_end", sb_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_coproc_sequencer.md
Name: fp_coproc_sequencer

Overview:
Issue/retire controller for the 16-bit pipeline's floating-point coprocessor (half-precision add/mul unit with a registered result and status).
- Accepts one FP op at a time from the ID/EX stage over a valid/ready handshake.
- Drives the coprocessor operand, op and rounding inputs from registers.
- Waits the coprocessor latency, then captures the result and status with the destination tag.
- Presents the result to writeback over a valid/ready handshake and keeps sticky exception flags.
- The coprocessor is instantiated beside this block by the parent, not inside it.

Parameters:
DATA_WIDTH, 16, operand/result width
STATUS_BIT, 8, coprocessor status width
TAG_WIDTH, 3, destination register tag width
FP_LATENCY, 1, coprocessor register stages between operand inputs and result (>=1)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
issue_valid_i  in  1  FP op request
issue_ready_o  out  1  sequencer can accept
issue_op_i  in  1  0=add, 1=mul
issue_rnd_i  in  3  rounding mode
issue_a_i  in  DATA_WIDTH  operand A
issue_b_i  in  DATA_WIDTH  operand B
issue_tag_i  in  TAG_WIDTH  destination register
flush_i  in  1  pipeline flush, abort in-flight op
cp_input1_o  out  DATA_WIDTH  coprocessor operand 1 (registered)
cp_input2_o  out  DATA_WIDTH  coprocessor operand 2 (registered)
cp_op_o  out  1  coprocessor op select (registered)
cp_rnd_o  out  3  coprocessor rounding (registered)
cp_result_i  in  DATA_WIDTH  coprocessor registered result
cp_status_i  in  STATUS_BIT  coprocessor registered status
wb_valid_o  out  1  result available
wb_ready_i  in  1  writeback consumes result
wb_data_o  out  DATA_WIDTH  result
wb_tag_o  out  TAG_WIDTH  destination register
wb_status_o  out  STATUS_BIT  status of this op
clr_flags_i  in  1  clear sticky flags
sticky_flags_o  out  STATUS_BIT  OR of retired op status
busy_o  out  1  state != IDLE

Behaviour:
- Reset: rst low asynchronously forces state IDLE, counter 0, and all outputs/registers to 0. issue_ready_o is 1 once rst is high. Reset mid-operation discards the op with no flag update.
- FSM states: IDLE, EXEC, RESULT.
- IDLE: issue_ready_o=1.
  - Accept on issue_valid_i & issue_ready_o: latch a, b, op, rnd into cp_* registers; latch tag; load cnt=FP_LATENCY; go to EXEC.
- EXEC: issue_ready_o=0. cp_* hold.
  - cnt decrements each cycle.
  - In the cycle with cnt==0, cp_result_i/cp_status_i are valid. At that edge, capture them into wb_data_o/wb_status_o and OR the status into the sticky flags; go to RESULT.
  - EXEC therefore lasts FP_LATENCY+1 cycles.
  - Latency: acceptance at edge E0 gives wb_valid_o high after edge E0+FP_LATENCY+1 (2 cycles for the default).
- RESULT: wb_valid_o=1; data, tag and status stable until consumed.
  - issue_ready_o = wb_ready_i (back-to-back: the retire edge may also accept a new op).
  - On wb_ready_i, with no new issue: go to IDLE, wb_valid_o=0.
  - On wb_ready_i with an issue accepted the same cycle: go to EXEC with the new operands.
- flush_i (highest priority):
  - Any state goes to IDLE at the next edge.
  - EXEC capture is suppressed: no flag update.
  - RESULT: wb_valid_o drops without retiring.
  - An issue presented in the flush cycle is not accepted (issue_ready_o=0 while flush_i=1).
- Sticky flags:
  - clr_flags_i alone clears to 0.
  - clr_flags_i together with a capture sets the flags to exactly the captured status (clear, then set).
  - Flags otherwise hold.
- cp_* outputs hold their last operands in IDLE (no toggling; saves power).
- busy_o is combinational from state.

Decomposition:
- Package fp_seq_pkg holds:
  - state encoding (IDLE=2'd0, EXEC=2'd1, RESULT=2'd2);
  - op constants FP_OP_ADD=1'b0, FP_OP_MUL=1'b1;
  - status bit indices (0 zero, 1 inf, 2 invalid, 3 tiny, 4 huge, 5 inexact).
- No sub-module: one FSM plus latency counter.
- The bench instantiates the coprocessor with its registered output alongside.

Test Plan:
- Add: a=0x3C00 (1.0), b=0x4000 (2.0), op=0, rnd=0 → wb_valid_o 2 cycles after accept, wb_data_o=0x4200, wb_status_o=0x00, tag echoed.
- Back-to-back with wb_ready_i tied 1: mul 0x4000×0x4000 then add 0x3C00+0x3C00 → results 0x4400 then 0x4000; new op accepted on the retire edge; issue_ready_o low during EXEC only.
- Overflow mul: 0x7BFF×0x7BFF, rnd=0 → wb_data_o=0x7C00, wb_status_o=0x32, sticky=0x32. Next clean op keeps sticky at 0x32. clr_flags_i coincident with a 0x20-status capture → sticky=0x20.
- Writeback stall: wb_ready_i low for 5 cycles → wb_valid_o/data/tag stable, issue_valid_i ignored, busy_o=1. Release → single retire.
- Flush in EXEC cycle 1 → no wb_valid_o, sticky unchanged, IDLE next cycle. Flush during RESULT → wb_valid_o drops without retiring.
- rst pulsed low mid-EXEC → all outputs 0 immediately (asynchronous). After release, a fresh add of 0x3C00+0x3C00 gives 0x4000 normally.
